line_card_port_scheduler: RTL and testbench
===========================================

LINE_CARD_PORT_SCHEDULER -- requirements
Module: line_card_port_scheduler

Interface
REQ-001 Parameter NUM_PORTS, default 24: number of ingress FIFOs arbitrated; legal range 2..24.
REQ-002 Parameter XBAR_THRESHOLD, default 189: minimum crossbar FIFO free words, exclusive, required before a grant is issued.
REQ-003 Parameter HOLDOFF_CYCLES, default 2: idle cycles inserted after each completed frame; legal range 0..15.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 areset_n  in  1  asynchronous active-low reset.
REQ-006 wr_ptr_committed  in  NUM_PORTS*13  per-port committed write pointer; port i occupies bits [13i+12:13i].
REQ-007 rd_ptr  in  NUM_PORTS*13  per-port read pointer, same packing as wr_ptr_committed.
REQ-008 port_reset  in  NUM_PORTS  per-port FIFO reset; port ineligible while high.
REQ-009 xbar_fifo_wsize  in  10  crossbar FIFO free space, in 64-bit words.
REQ-010 grant_valid  out  1  grant offered to the FIFO reader.
REQ-011 grant_port  out  5  index of the granted port.
REQ-012 grant_ready  in  1  reader accepts the grant.
REQ-013 done  in  1  single-cycle pulse: reader finished the granted frame.
REQ-014 busy  out  1  high from grant acceptance through the end of holdoff.
REQ-015 protocol_error  out  1  sticky: done seen outside BUSY.
REQ-016 grant_count  out  32  accepted grants; statistics build only.
REQ-017 xbar_stall_count  out  32  cycles stalled on crossbar space; statistics build only.

Function
REQ-018 pending[i] SHALL be ((wr_ptr_committed[i] - rd_ptr[i]) mod 8192) != 0, computed in 13 bits with wrap.
REQ-019 eligible[i] SHALL be pending[i] && !port_reset[i], for i < NUM_PORTS only.
REQ-020 xbar_ok SHALL be xbar_fifo_wsize > XBAR_THRESHOLD (unsigned compare).
REQ-021 States SHALL be IDLE, GRANT, BUSY and HOLDOFF.
REQ-022 IDLE: if any eligible and xbar_ok, select the first eligible port searching from last_port+1 upward, wrapping modulo NUM_PORTS; register it into grant_port; go to GRANT.
REQ-023 Eligibility sampled in cycle N SHALL produce grant_valid=1 in cycle N+1.
REQ-024 GRANT: grant_valid and grant_port SHALL hold stable until grant_ready=1.
REQ-025 GRANT: on grant_ready=1, last_port <= grant_port, grant_valid <= 0, busy <= 1, and the state goes to BUSY.
REQ-026 GRANT: if port_reset[grant_port]=1 and grant_ready=0, withdraw the grant: grant_valid <= 0, return to IDLE, last_port unchanged.
REQ-027 GRANT: if grant_ready and port_reset[grant_port] are high in the same cycle, the accept SHALL win.
REQ-028 BUSY: on done=1 go to HOLDOFF, loading the holdoff counter with HOLDOFF_CYCLES; if HOLDOFF_CYCLES=0, go directly to IDLE with busy <= 0.
REQ-029 BUSY: port_reset changes SHALL be ignored; the reader owns frame abort.
REQ-030 HOLDOFF: decrement the counter each cycle; at 0 go to IDLE with busy <= 0.
REQ-031 done=1 in IDLE, GRANT or HOLDOFF SHALL set protocol_error, and the state SHALL be unchanged.
REQ-032 xbar_ok is evaluated only in IDLE; a drop in crossbar space after a grant SHALL NOT withdraw the grant.

Reset
REQ-033 On areset_n=0, asynchronously: state IDLE, grant_valid 0, grant_port 0, busy 0, protocol_error 0, counters 0, holdoff counter 0, last_port NUM_PORTS-1 (port 0 served first).
REQ-034 Outputs SHALL update only on rising clk edges after reset deasserts.

Configuration
REQ-035 Macro LINE_CARD_SCHED_STATS_EN, when defined: grant_count increments on each accepted grant.
REQ-036 With LINE_CARD_SCHED_STATS_EN defined: xbar_stall_count increments each IDLE cycle where an eligible port exists but xbar_ok=0; both counters saturate at 0xFFFFFFFF.
REQ-037 Without LINE_CARD_SCHED_STATS_EN: both counter ports SHALL remain present and tied to 0, and no counter logic SHALL be synthesized.

Verification
REQ-038 Ports 3, 7 and 20 pending, xbar_fifo_wsize=500, grant_ready=1, done 5 cycles after each grant -> grants in order 3, 7, 20, 3, with 2 holdoff cycles between them.
REQ-039 wr_ptr_committed[5]=0x0002, rd_ptr[5]=0x1FFE -> port 5 eligible and granted; equal pointers -> never granted.
REQ-040 Port 0 pending, xbar_fifo_wsize=189 -> no grant and stall count increments; set to 190 -> grant_valid next cycle.
REQ-041 Grant to port 9 held, grant_ready=0, then port_reset[9]=1 -> grant_valid drops the next cycle; a later grant search restarts after the previous last_port.
REQ-042 done pulse in IDLE -> protocol_error=1 and stays set until areset_n=0.
REQ-043 areset_n asserted mid-BUSY -> all outputs 0 immediately; first grant after release goes to the lowest eligible port.

Source files
------------

// File: rtl/line_card_port_scheduler.sv
// Round-robin grant scheduler over NUM_PORTS ingress FIFOs, gated on crossbar space.
// Define LINE_CARD_SCHED_STATS_EN to build the grant and stall counters.
module line_card_port_scheduler #(
  parameter int NUM_PORTS      = 24,
  parameter int XBAR_THRESHOLD = 189,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic [NUM_PORTS*13-1:0] wr_ptr_committed,
  input  logic [NUM_PORTS*13-1:0] rd_ptr,
  input  logic [NUM_PORTS-1:0]   port_reset,
  input  logic [9:0]             xbar_fifo_wsize,
  output logic                   grant_valid,
  output logic [4:0]             grant_port,
  input  logic                   grant_ready,
  input  logic                   done,
  output logic                   busy,
  output logic                   protocol_error,
  output logic [31:0]            grant_count,
  output logic [31:0]            xbar_stall_count
);

  typedef enum logic [1:0] {
    IDLE, GRANT, BUSY, HOLDOFF
  } state_t;

  localparam logic [10:0] XTH  = 11'(XBAR_THRESHOLD);
  localparam logic [3:0]  HOLD = 4'(HOLDOFF_CYCLES);
  localparam logic [4:0]  LAST = 5'(NUM_PORTS - 1);

  state_t               state;
  logic [4:0]           last_port;
  logic [3:0]           hold_cnt;
  logic [NUM_PORTS-1:0] eligible;
  logic                 any_elig;
  logic                 xbar_ok;
  logic [4:0]           sel;
  logic                 found;
  int                   idx;

  // Pointer difference wraps in 13 bits, so a wrapped writer still reads as pending.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = ((wr_ptr_committed[13*i +: 13]
                    - rd_ptr[13*i +: 13]) != 13'd0)
                    && !port_reset[i];
    end
  end

  assign any_elig = |eligible;
  assign xbar_ok  = {1'b0, xbar_fifo_wsize} > XTH;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(last_port) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && eligible[5'(idx)]) begin
        found = 1'b1;
        sel   = 5'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state          <= IDLE;
      grant_valid    <= 1'b0;
      grant_port     <= '0;
      busy           <= 1'b0;
      protocol_error <= 1'b0;
      hold_cnt       <= '0;
      last_port      <= LAST;
    end else begin
      unique case (state)
        IDLE: begin
          if (done) begin
            protocol_error <= 1'b1;
          end else if (any_elig && xbar_ok) begin
            grant_port  <= sel;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (done) begin
            protocol_error <= 1'b1;
          end else if (grant_ready) begin
            last_port   <= grant_port;
            grant_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= BUSY;
          end else if (port_reset[grant_port]) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        BUSY: begin
          if (done) begin
            if (HOLD == 4'd0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              hold_cnt <= HOLD;
              state    <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (done) begin
            protocol_error <= 1'b1;
          end else if (hold_cnt <= 4'd1) begin
            hold_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_CARD_SCHED_STATS_EN
  logic accept;
  logic stall;

  assign accept = (state == GRANT) && grant_ready && !done;
  assign stall  = (state == IDLE) && any_elig && !xbar_ok;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      grant_count      <= '0;
      xbar_stall_count <= '0;
    end else begin
      if (accept && grant_count != '1)
        grant_count <= grant_count + 32'd1;
      if (stall && xbar_stall_count != '1)
        xbar_stall_count <= xbar_stall_count + 32'd1;
    end
  end
`else
  assign grant_count      = '0;
  assign xbar_stall_count = '0;
`endif

endmodule

// File: tb/tb_line_card_port_scheduler.sv
// Directed-vector bench for line_card_port_scheduler.
// Counter expectations follow LINE_CARD_SCHED_STATS_EN.
module tb_line_card_port_scheduler;

  localparam int NP = 24;

  logic           clk;
  logic           areset_n;
  logic [NP*13-1:0] wr;
  logic [NP*13-1:0] rd;
  logic [NP-1:0]  port_reset;
  logic [9:0]     wsize;
  logic           grant_valid;
  logic [4:0]     grant_port;
  logic           grant_ready;
  logic           done;
  logic           busy;
  logic           protocol_error;
  logic [31:0]    grant_count;
  logic [31:0]    xbar_stall_count;

  int vecs;
  int errs;

  line_card_port_scheduler dut (
    .clk              (clk),
    .areset_n         (areset_n),
    .wr_ptr_committed (wr),
    .rd_ptr           (rd),
    .port_reset       (port_reset),
    .xbar_fifo_wsize  (wsize),
    .grant_valid      (grant_valid),
    .grant_port       (grant_port),
    .grant_ready      (grant_ready),
    .done             (done),
    .busy             (busy),
    .protocol_error   (protocol_error),
    .grant_count      (grant_count),
    .xbar_stall_count (xbar_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LINE_CARD_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ptr(input int p,
                         input logic [12:0] w,
                         input logic [12:0] r);
    wr[13*p +: 13] = w;
    rd[13*p +: 13] = r;
  endtask

  // Waits for a grant, checks port and latency, then lets it be accepted.
  task automatic get_grant(input logic [4:0] exp,
                           input int max_wait);
    int n;
    n = 0;
    while (!grant_valid && n < 20) begin
      step();
      n++;
    end
    chk("grant_valid", 32'(grant_valid), 32'd1);
    chk("grant_port", 32'(grant_port), 32'(exp));
    if (max_wait > 0)
      chk("grant_latency", 32'(n <= max_wait), 32'd1);
    grant_ready = 1'b1;
    step();
    chk("busy_on_accept", 32'(busy), 32'd1);
  endtask

  task automatic finish_frame();
    int n;
    repeat (4) step();
    done = 1'b1;
    step();
    done = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    chk("holdoff_cycles", 32'(n), 32'd2);
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    areset_n    = 1'b0;
    wr          = '0;
    rd          = '0;
    port_reset  = '0;
    wsize       = 10'd0;
    grant_ready = 1'b0;
    done        = 1'b0;
    repeat (3) step();
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_gp", 32'(grant_port), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);
    chk("rst_gcnt", grant_count, 32'd0);
    chk("rst_scnt", xbar_stall_count, 32'd0);
    areset_n = 1'b1;
    step();

    // Round robin 3, 7, 20, 3
    wsize       = 10'd500;
    grant_ready = 1'b1;
    set_ptr(3, 13'd1, 13'd0);
    set_ptr(7, 13'd1, 13'd0);
    set_ptr(20, 13'd1, 13'd0);
    step();
    chk("first_gv", 32'(grant_valid), 32'd1);
    get_grant(5'd3, 0);
    finish_frame();
    get_grant(5'd7, 1);
    finish_frame();
    get_grant(5'd20, 1);
    finish_frame();
    get_grant(5'd3, 1);
    wr = '0;
    rd = '0;
    finish_frame();

    // Wrapped pointers pending; equal pointers never pending
    set_ptr(6, 13'h0155, 13'h0155);
    set_ptr(5, 13'h0002, 13'h1FFE);
    get_grant(5'd5, 0);
    set_ptr(5, 13'h0002, 13'h0002);
    finish_frame();
    repeat (3) step();
    chk("equal_ptr_gv", 32'(grant_valid), 32'd0);

    // Crossbar threshold is exclusive
    wsize = 10'd189;
    set_ptr(0, 13'd4, 13'd0);
    repeat (3) step();
    chk("xbar189_gv", 32'(grant_valid), 32'd0);
    chk("stall_cnt", xbar_stall_count,
        STATS ? 32'd3 : 32'd0);
    wsize = 10'd190;
    step();
    chk("xbar190_gv", 32'(grant_valid), 32'd1);
    chk("xbar190_gp", 32'(grant_port), 32'd0);
    step();
    chk("accept0_busy", 32'(busy), 32'd1);
    set_ptr(0, 13'd0, 13'd0);
    finish_frame();
    chk("grant_cnt", grant_count,
        STATS ? 32'd6 : 32'd0);
    chk("stall_hold", xbar_stall_count,
        STATS ? 32'd3 : 32'd0);

    // Withdraw on port reset; last_port stays at 0
    grant_ready = 1'b0;
    set_ptr(9, 13'd3, 13'd1);
    step();
    step();
    chk("p9_gv", 32'(grant_valid), 32'd1);
    chk("p9_gp", 32'(grant_port), 32'd9);
    step();
    step();
    chk("p9_hold_gv", 32'(grant_valid), 32'd1);
    chk("p9_hold_gp", 32'(grant_port), 32'd9);
    port_reset[9] = 1'b1;
    set_ptr(4, 13'd1, 13'd0);
    set_ptr(15, 13'd1, 13'd0);
    step();
    chk("withdraw_gv", 32'(grant_valid), 32'd0);
    step();
    chk("regrant_gv", 32'(grant_valid), 32'd1);
    chk("regrant_gp", 32'(grant_port), 32'd4);
    grant_ready = 1'b1;
    wr = '0;
    rd = '0;
    port_reset = '0;
    step();
    chk("p4_busy", 32'(busy), 32'd1);
    finish_frame();

    // Done in IDLE is a sticky protocol error
    chk("perr_clean", 32'(protocol_error), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("perr_set", 32'(protocol_error), 32'd1);
    repeat (3) step();
    chk("perr_sticky", 32'(protocol_error), 32'd1);

    // Async reset mid-BUSY
    set_ptr(2, 13'd1, 13'd0);
    set_ptr(11, 13'd1, 13'd0);
    get_grant(5'd11, 0);
    #2;
    areset_n = 1'b0;
    #1;
    chk("arst_gv", 32'(grant_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_perr", 32'(protocol_error), 32'd0);
    chk("arst_gp", 32'(grant_port), 32'd0);
    chk("arst_gcnt", grant_count, 32'd0);
    step();
    areset_n = 1'b1;
    get_grant(5'd2, 0);
    wr = '0;
    rd = '0;
    finish_frame();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
